// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state enum and widths for the instruction-fetch stage
package fetch_pkg;
  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: redirect, instruction-memory and decode handshakes of the fetch stage
interface fetch_if;
  import fetch_pkg::*;
  logic fetch_en;
  logic redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic imem_ready;
  logic imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic id_valid;
  logic [INST_W-1:0] id_inst;
  logic [ADDR_W-1:0] id_pc;
  logic id_ready;
  logic misalign_err;
  modport master(
    input fetch_en, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_inst, id_pc, misalign_err
  );
  modport slave(
    output fetch_en, redirect_valid, redirect_pc, imem_ready, imem_rvalid, imem_rdata, id_ready,
    input imem_req, imem_addr, id_valid, id_inst, id_pc, misalign_err
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with synchronous clear, zero output when empty
module fetch_queue #(
  parameter int W = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = push ? inc(wp_q) : wp_q;
    rp_d = pop ? inc(rp_q) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst || clr) begin
      rp_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
    end else begin
      rp_q <= rp_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
    end
  end
  assign count = cnt_q;
  assign dout = (cnt_q != '0) ? mem_q[rp_q] : '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC sequencing, imem requests and decode queue; FETCH_MISALIGN_CHK_EN adds misaligned-redirect halt
module fetch_unit import fetch_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int FQ_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  fetch_if.master f
);
  localparam int CW = $clog2(FQ_DEPTH + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, tgt, rsp_pc;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d, occ, outstanding;
  logic [INST_W+ADDR_W-1:0] head;
  logic mis, accept, enq, deq, flush;
  assign flush = f.redirect_valid;
  assign accept = f.imem_req & f.imem_ready;
  assign deq = f.id_valid & f.id_ready & ~flush;
  assign enq = f.imem_rvalid & ~flush & (drop_cnt_q == '0);
  assign f.imem_req = (state_q == RUN) && (int'(occ) - int'(deq) + int'(outstanding) < FQ_DEPTH) && !flush && !rst;
  assign f.imem_addr = fetch_pc_q;
  assign f.id_valid = occ != '0;
  assign {f.id_inst, f.id_pc} = head;
`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q, err_d;
  assign mis = flush & (f.redirect_pc[1:0] != 2'b00);
  assign tgt = f.redirect_pc;
  assign err_d = err_q | mis;
  assign f.misalign_err = err_q;
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
`else
  assign mis = 1'b0;
  assign tgt = f.redirect_pc & ~ADDR_W'(3);
  assign f.misalign_err = 1'b0;
`endif
  always_comb begin
    state_d = (state_q == IDLE && f.fetch_en) ? RUN : (state_q == RUN && !f.fetch_en) ? IDLE : state_q;
`ifdef FETCH_MISALIGN_CHK_EN
    if (flush) state_d = mis ? HALT : (state_q == HALT) ? RUN : state_d;
`endif
    fetch_pc_d = flush ? (mis ? fetch_pc_q : tgt) : accept ? fetch_pc_q + PC_STEP : fetch_pc_q;
    drop_cnt_d = flush ? outstanding - CW'(f.imem_rvalid) : drop_cnt_q - CW'(f.imem_rvalid && drop_cnt_q != '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  fetch_queue #(.W(ADDR_W), .DEPTH(FQ_DEPTH)) u_addr (
    .clk(clk), .rst(rst), .clr(1'b0),
    .push(accept), .din(f.imem_addr),
    .pop(f.imem_rvalid), .dout(rsp_pc), .count(outstanding)
  );
  fetch_queue #(.W(INST_W + ADDR_W), .DEPTH(FQ_DEPTH)) u_inst (
    .clk(clk), .rst(rst), .clr(flush),
    .push(enq), .din({f.imem_rdata, rsp_pc}),
    .pop(deq), .dout(head), .count(occ)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit with a behavioural memory and PC-stream model
module tb_fetch_unit;
  import fetch_pkg::*;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  typedef struct {logic [31:0] d; int due;} rsp_t;
  logic clk = 1'b0;
  logic rst;
  int nchk = 0, nerr = 0, cyc = 0, ndeq = 0;
  int lat_lo = 1, lat_hi = 1;
  bit rand_ready = 0;
  rsp_t pend[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;
  fetch_if f();
  fetch_unit #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (.clk(clk), .rst(rst), .f(f));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic restart(input logic [31:0] a);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(a + 32'(4 * i));
    exp_addr = a;
  endtask
  task automatic redirect(input logic [31:0] a);
    f.redirect_valid = 1'b1;
    f.redirect_pc = a;
`ifdef FETCH_MISALIGN_CHK_EN
    if (a[1:0] != 2'b00) exp_q.delete();
    else restart(a);
`else
    restart(a & ~32'h3);
`endif
  endtask
  initial begin
    f.imem_ready = 1'b1;
    f.imem_rvalid = 1'b0;
    f.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else if (f.imem_req && f.imem_ready) begin
        chk("imem_addr", f.imem_addr, exp_addr);
        exp_addr += 32'd4;
        pend.push_back('{f.imem_addr ^ KEY, cyc + int'($urandom_range(lat_hi, lat_lo))});
      end
      @(posedge clk);
      #1;
      cyc++;
      f.imem_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      f.imem_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        f.imem_rvalid = 1'b1;
        f.imem_rdata = pend[0].d;
        void'(pend.pop_front());
      end
    end
  end
  initial begin
    logic pstall;
    logic [31:0] ppc, pinst, e;
    pstall = 1'b0;
    ppc = '0;
    pinst = '0;
    forever begin
      @(negedge clk);
      if (pstall) begin
        chk("hold_valid", 32'(f.id_valid), 32'd1);
        chk("hold_pc", f.id_pc, ppc);
        chk("hold_inst", f.id_inst, pinst);
      end
      if (!rst && !f.redirect_valid && f.id_valid && f.id_ready) begin
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_dequeue: got id_pc %h expected none", f.id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", f.id_pc, e);
          chk("id_inst", f.id_inst, e ^ KEY);
        end
        ndeq++;
      end
      pstall = !rst && !f.redirect_valid && f.id_valid && !f.id_ready;
      ppc = f.id_pc;
      pinst = f.id_inst;
    end
  end
  initial begin
    int d0;
    int i;
    rst = 1'b1;
    f.fetch_en = 1'b1;
    f.redirect_valid = 1'b0;
    f.redirect_pc = '0;
    f.id_ready = 1'b1;
    restart(32'h0);
    tick(1);
    @(negedge clk);
    chk("rst_imem_req", 32'(f.imem_req), 32'd0);
    chk("rst_id_valid", 32'(f.id_valid), 32'd0);
    chk("rst_id_inst", f.id_inst, 32'd0);
    chk("rst_id_pc", f.id_pc, 32'd0);
    chk("rst_misalign", 32'(f.misalign_err), 32'd0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req", 32'(f.imem_req), 32'd0);
    tick(1);
    @(negedge clk);
    chk("first_req", 32'(f.imem_req), 32'd1);
    chk("first_addr", f.imem_addr, 32'h0);
    tick(6);
    d0 = ndeq;
    tick(10);
    chk("throughput", 32'(ndeq - d0), 32'd10);
    f.id_ready = 1'b0;
    tick(5);
    @(negedge clk);
    chk("bp_valid", 32'(f.id_valid), 32'd1);
    chk("bp_req", 32'(f.imem_req), 32'd0);
    chk("bp_occupancy", 32'(dut.occ), 32'd2);
    tick(1);
    f.id_ready = 1'b1;
    tick(6);
    lat_lo = 3;
    lat_hi = 3;
    i = 0;
    while (i < 20 && pend.size() != 2) begin
      tick(1);
      #2;
      i++;
    end
    chk("two_outstanding", 32'(pend.size()), 32'd2);
    redirect(32'h100);
    tick(1);
    f.redirect_valid = 1'b0;
    lat_lo = 1;
    lat_hi = 1;
    tick(10);
    redirect(32'h300);
    @(negedge clk);
    chk("coincide", {29'd0, f.imem_rvalid, f.id_valid, f.id_ready}, 32'd7);
    tick(1);
    f.redirect_valid = 1'b0;
    @(negedge clk);
    chk("bubble1", 32'(f.id_valid), 32'd0);
    chk("drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    tick(1);
    @(negedge clk);
    chk("bubble2", 32'(f.id_valid), 32'd0);
    tick(1);
    @(negedge clk);
    chk("after_bubble", 32'(f.id_valid), 32'd1);
    chk("after_bubble_pc", f.id_pc, 32'h300);
    tick(4);
    redirect(32'hFFFF_FFF8);
    tick(1);
    f.redirect_valid = 1'b0;
    tick(10);
    redirect(32'h102);
    tick(1);
    f.redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_err", 32'(f.misalign_err), 32'd1);
    chk("mis_req", 32'(f.imem_req), 32'd0);
    tick(3);
    @(negedge clk);
    chk("halt_req", 32'(f.imem_req), 32'd0);
`else
    chk("mis_err_off", 32'(f.misalign_err), 32'd0);
    tick(3);
`endif
    tick(1);
    redirect(32'h200);
    tick(1);
    f.redirect_valid = 1'b0;
    @(negedge clk);
    chk("resume_req", 32'(f.imem_req), 32'd1);
    chk("resume_addr", f.imem_addr, 32'h200);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_sticky", 32'(f.misalign_err), 32'd1);
`else
    chk("mis_sticky_off", 32'(f.misalign_err), 32'd0);
`endif
    tick(8);
    lat_hi = 3;
    rand_ready = 1;
    d0 = ndeq;
    for (int k = 0; k < 4000; k++) begin
      f.id_ready = 1'($urandom_range(3, 0) != 0);
      f.redirect_valid = 1'b0;
      if ($urandom_range(499, 0) == 0) begin
        rst = 1'b1;
        restart(32'h0);
        tick(2);
        rst = 1'b0;
      end else if ($urandom_range(31, 0) == 0) redirect($urandom() & ~32'h3);
      if ($urandom_range(63, 0) == 0) f.fetch_en = ~f.fetch_en;
      if ($urandom_range(7, 0) == 0) f.fetch_en = 1'b1;
      tick(1);
    end
    f.redirect_valid = 1'b0;
    chk("progress", 32'(ndeq - d0 > 500), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
